// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// uart_tx_queue : FIFO-buffered UART transmitter (parity, 1/2 stop bits, flush)
// Rev 1.0
// ============================================================================
module uart_tx_queue #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 512,
  parameter int DATA_W      = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_busy,
  output logic                     uart_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] C_BAUD_MAX = BW'(CLK_PER_BIT - 1);

  if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
    $error("uart_tx_queue: CLK_PER_BIT must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_queue: DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 5 || DATA_W > 8) begin : g_bad_data_w
    $error("uart_tx_queue: DATA_W must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_queue: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_queue: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              rdy_en_q, rdy_en_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic       full, wr_en, baud_done, last_stop, pop, par_bit;
  logic [2:0] next_idx;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == PW'(DEPTH));
  assign wr_ready  = rdy_en_q && !full && !flush;
  assign wr_en     = wr_valid && wr_ready;
  assign baud_done = (baud_q == '0);
  assign last_stop = (state_q == S_STOP) && baud_done && (bit_q == 3'(STOP_BITS - 1));
  // Popping on the final stop cycle chains frames with no idle gap.
  assign pop       = ((state_q == S_IDLE) || last_stop) && (count != '0);
  assign next_idx  = bit_q + 3'd1;
  assign par_bit   = (PARITY == 1) ? ^shreg_q : ~^shreg_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign uart_tx   = tx_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_done ? C_BAUD_MAX : baud_q - BW'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    rdy_en_d = 1'b1;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? wr_ptr_q : (pop ? rd_ptr_q + PW'(1) : rd_ptr_q);

    case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_q == 3'(DATA_W - 1)) begin
            bit_d = 3'd0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = next_idx;
            tx_d  = shreg_q[next_idx];
          end
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (last_stop) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else if (baud_done) begin
          bit_d = next_idx;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d = S_START;
      baud_d  = C_BAUD_MAX;
      shreg_d = mem_q[rd_ptr_q[AW-1:0]];
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      rdy_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      rdy_en_q <= rdy_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_queue : cycle-level reference model bench for uart_tx_queue
// Rev 1.0
// ============================================================================
module tb_uart_tx_queue;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int FRM = (1 + 8 + 0 + 1) * CPB;       // main: 8N1
  localparam int FEV = (1 + 8 + 1 + 2) * CPB;       // even parity, 2 stop
  localparam int FOD = (1 + 5 + 1 + 1) * CPB;       // 5 bits, odd parity

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0, flush = 1'b0, wr_ready, tx_busy, uart_tx;
  logic [2:0] count;

  logic [7:0] ev_data = '0;
  logic       ev_valid = 1'b0, ev_flush = 1'b0, ev_ready, ev_busy, ev_tx;
  logic [2:0] ev_count;
  logic [4:0] od_data = '0;
  logic       od_valid = 1'b0, od_flush = 1'b0, od_ready, od_busy, od_tx;
  logic [2:0] od_count;

  always #5 clk = ~clk;

  uart_tx_queue #(.CLK_PER_BIT(CPB), .DEPTH(DEP), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .flush(flush), .count(count), .tx_busy(tx_busy), .uart_tx(uart_tx));

  uart_tx_queue #(.CLK_PER_BIT(CPB), .DEPTH(DEP), .DATA_W(8), .PARITY(1), .STOP_BITS(2)) u_even (
    .clk(clk), .rst_n(rst_n), .wr_data(ev_data), .wr_valid(ev_valid), .wr_ready(ev_ready),
    .flush(ev_flush), .count(ev_count), .tx_busy(ev_busy), .uart_tx(ev_tx));

  uart_tx_queue #(.CLK_PER_BIT(CPB), .DEPTH(DEP), .DATA_W(5), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .wr_data(od_data), .wr_valid(od_valid), .wr_ready(od_ready),
    .flush(od_flush), .count(od_count), .tx_busy(od_busy), .uart_tx(od_tx));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state for the main instance
  int         cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] cur = '0;
  int         pop_cyc = -1000;
  int         frame_end = -1000;
  bit         ready_en = 0;
  bit         last_acc = 0;
  int         par_t0 = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Level on the line k cycles into a frame carrying byte d
  function automatic logic exp_bit(input logic [7:0] d, input int k, input int dw, input int par);
    int b;
    logic [7:0] m;
    b = k / CPB;
    m = d & 8'((1 << dw) - 1);
    if (b == 0) return 1'b0;
    if (b <= dw) return m[b-1];
    if (par != 0 && b == dw + 1) return (par == 1) ? ^m : ~^m;
    return 1'b1;
  endfunction

  task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic f);
    logic exp_rdy, in_frame, exp_tx;
    int k;
    logic [7:0] bb;
    @(negedge clk);
    rst_n    = r;
    wr_valid = v;
    wr_data  = d;
    flush    = f;
    ev_valid = (par_t0 >= 0) && (cyc == par_t0 || cyc == par_t0 + 1);
    od_valid = ev_valid;
    ev_data  = (cyc == par_t0) ? 8'h07 : 8'hC3;
    od_data  = (cyc == par_t0) ? 5'h07 : 5'h1B;
    #1;
    if (!r) begin
      mq.delete();
      pop_cyc   = -1000;
      frame_end = -1000;
      ready_en  = 0;
    end
    exp_rdy  = ready_en && (mq.size() < DEP) && !f;
    in_frame = (cyc > pop_cyc) && (cyc <= frame_end);
    exp_tx   = in_frame ? exp_bit(cur, cyc - pop_cyc - 1, 8, 0) : 1'b1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    chk("tx_busy", 32'(tx_busy), 32'(in_frame));
    chk("uart_tx", 32'(uart_tx), 32'(exp_tx));

    if (par_t0 >= 0) begin
      k = cyc - par_t0 - 2;
      if (k >= -2 && k < 2 * FEV + 4) begin
        bb = (k < FEV) ? 8'h07 : 8'hC3;
        chk("even_tx", 32'(ev_tx), (k >= 0 && k < 2 * FEV) ? 32'(exp_bit(bb, k % FEV, 8, 1)) : 32'd1);
        chk("even_busy", 32'(ev_busy), 32'(k >= 0 && k < 2 * FEV));
      end
      if (k >= -2 && k < 2 * FOD + 4) begin
        bb = (k < FOD) ? 8'h07 : 8'h1B;
        chk("odd_tx", 32'(od_tx), (k >= 0 && k < 2 * FOD) ? 32'(exp_bit(bb, k % FOD, 5, 2)) : 32'd1);
      end
    end

    last_acc = v && exp_rdy;
    if (r) begin
      if (cyc >= frame_end && mq.size() > 0) begin
        cur       = mq.pop_front();
        pop_cyc   = cyc;
        frame_end = cyc + FRM;
      end
      if (last_acc) mq.push_back(d);
      if (f) mq.delete();
      ready_en = 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] six[6];
    int idx;

    // Reset state, then release
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Single frame 0xA5
    tick(1'b1, 1'b1, 8'hA5, 1'b0);
    idle(45);

    // Three back-to-back frames
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    tick(1'b1, 1'b1, 8'hFF, 1'b0);
    tick(1'b1, 1'b1, 8'h55, 1'b0);
    idle(3 * FRM + 5);

    // Full FIFO with WR_VALID held
    six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0;
    for (int n = 0; n < 200 && idx < 6; n++) begin
      tick(1'b1, 1'b1, six[idx], 1'b0);
      if (last_acc) idx++;
    end
    chk("full_all_accepted", 32'(idx), 32'd6);
    idle(6 * FRM + 5);

    // Flush mid-frame with three bytes queued
    tick(1'b1, 1'b1, 8'hC1, 1'b0);
    tick(1'b1, 1'b1, 8'hC2, 1'b0);
    tick(1'b1, 1'b1, 8'hC3, 1'b0);
    tick(1'b1, 1'b1, 8'hC4, 1'b0);
    idle(15);
    tick(1'b1, 1'b1, 8'hEE, 1'b1);
    idle(FRM + 10);

    // Reset mid-DATA, then a clean 0x3C frame
    tick(1'b1, 1'b1, 8'h81, 1'b0);
    tick(1'b1, 1'b1, 8'h82, 1'b0);
    idle(12);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b1, 8'h3C, 1'b0);
    idle(FRM + 5);

    // Parity / stop-bit instances
    par_t0 = cyc;
    idle(2 * FEV + 6);
    par_t0 = -1;

    // Randomized traffic with occasional flush
    for (int i = 0; i < 1500; i++) begin
      tick(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 99) == 0));
    end
    idle(DEP * FRM + 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
